// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encoding, sequencer states and the divide special-case constants.
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FIXUP   = 3'd2,
        SPECIAL = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic op_a_signed(input logic [2:0] mode);
        return (mode == MUL) || (mode == MULH) || (mode == MULHSU) ||
               (mode == DIV) || (mode == REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] mode);
        return (mode == MUL) || (mode == MULH) || (mode == DIV) || (mode == REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath for one radix-2 iteration per step: shift-add multiply into {hi,lo},
// or restoring shift-subtract divide with remainder in hi and quotient in lo.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shl;
    logic [XLEN:0]   diff;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        add_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
        shl     = {hi_q, lo_q[XLEN-1]};
        diff    = shl - {1'b0, b_q};
        if (div_i) begin
            // Borrow out of the XLEN+1 bit subtract means the trial failed: restore.
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shl[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load_i) begin
            hi_q <= '0;
            lo_q <= a_i;
            b_q  <= b_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: sequencer, sign handling and divide
// special cases around the shared shift-add / shift-subtract core.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      mul_mode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] result
);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          mode_q;
    logic [XLEN-1:0]     a_raw_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic                bzero_q;
    logic [XLEN-1:0]     stage_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                sgn_a, sgn_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                is_special;
    logic [XLEN-1:0]     core_hi, core_lo;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s;
    logic [XLEN-1:0]     fix_res, spec_res;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready && !flush;

    // Magnitudes are taken unsigned, so INT_MIN becomes 2^(XLEN-1) without overflow.
    always_comb begin
        sgn_a      = op_a_signed(mul_mode) && op_a[XLEN-1];
        sgn_b      = op_b_signed(mul_mode) && op_b[XLEN-1];
        mag_a      = sgn_a ? (~op_a + 1'b1) : op_a;
        mag_b      = sgn_b ? (~op_b + 1'b1) : op_b;
        is_special = mul_mode[2] &&
                     ((op_b == '0) ||
                      (((mul_mode == DIV) || (mul_mode == REM)) &&
                       (op_a == INT_MIN) && (op_b == '1)));
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (accept),
        .step_i (state_q == CALC),
        .div_i  (mode_q[2]),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? (~{core_hi, core_lo} + 1'b1) : {core_hi, core_lo};
        quo_s  = (sign_a_q ^ sign_b_q) ? (~core_lo + 1'b1) : core_lo;
        rem_s  = sign_a_q ? (~core_hi + 1'b1) : core_hi;
        case (mode_q)
            MUL:                 fix_res = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quo_s;
            default:             fix_res = rem_s;
        endcase
        if (bzero_q) begin
            spec_res = mode_q[1] ? a_raw_q : DIV_BY_ZERO_Q;
        end else begin
            spec_res = mode_q[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= '0;
            a_raw_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            stage_q  <= '0;
            result_q <= '0;
        end else begin
            if ((state_q == DONE) && !flush) begin
                result_q <= stage_q;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mode_q   <= mul_mode;
                        a_raw_q  <= op_a;
                        sign_a_q <= sgn_a;
                        sign_b_q <= sgn_b;
                        bzero_q  <= (op_b == '0);
                        cnt_q    <= CNT_W'(XLEN - 1);
                        state_q  <= is_special ? SPECIAL : CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= FIXUP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIXUP: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        stage_q <= fix_res;
                        state_q <= DONE;
                    end
                end
                SPECIAL: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        stage_q <= spec_res;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The staged result is committed only when the DONE pulse survives a flush,
    // so a flush during DONE leaves the visible result untouched.
    assign busy      = (state_q != IDLE);
    assign stall     = busy || (req_valid && req_ready);
    assign res_valid = (state_q == DONE) && !flush;
    assign result    = res_valid ? stage_q : result_q;

endmodule
